// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types and defaults for the memory port arbiter.
// Holds the FSM state enum, the owner enum and the parameter defaults.
package riscv_mem_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection between fetch and data.
// Ports: if_req, d_req, last_owner in; owner out. MEM_ARB_RR_EN selects RR.
module mem_arb_pick
  import riscv_mem_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_e last_owner,
  output owner_e owner
);

`ifdef MEM_ARB_RR_EN
  // On a tie, hand the port to whoever did not have it last.
  always_comb begin
    owner = OWN_D;
    unique case (1'b1)
      (if_req && d_req):
        owner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
      (if_req && !d_req):
        owner = OWN_IF;
      default:
        owner = OWN_D;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last_owner;

  always_comb begin
    owner = OWN_D;
    if (if_req && !d_req)
      owner = OWN_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data masters.
// Ports: clk, async active-low reset; if_* fetch, d_* data, mem_* memory
// side; busy and sticky timeout_err status. MEM_ARB_RR_EN: round-robin.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = 8;

  state_e            state_q;
  owner_e            own_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              err_q;

  owner_e            pick_own;
  owner_e            last_own;
  logic              take;
  logic              tmo;
  logic              done;
  logic [DATA_W-1:0] resp_d;

  mem_arb_pick u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .last_owner(last_own),
    .owner     (pick_own)
  );

  // Grant is combinational in IDLE; forced low while reset is held.
  assign take = reset && (state_q == IDLE) && (if_req || d_req);

  assign if_gnt = take && (pick_own == OWN_IF);
  assign d_gnt  = take && (pick_own == OWN_D);

  // Ready on the limit cycle wins over the timeout.
  assign tmo  = !mem_ready &&
                (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign done = mem_ready || tmo;

  // Writes and timeouts both return zero data.
  assign resp_d = (mem_ready && !we_q) ? mem_rdata : '0;

`ifdef MEM_ARB_RR_EN
  owner_e last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_q <= OWN_IF;
    else if (take)
      last_q <= pick_own;
  end

  assign last_own = last_q;
`else
  assign last_own = OWN_IF;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      own_q      <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            own_q   <= pick_own;
            cnt_q   <= '0;
            state_q <= BUSY;
            if (pick_own == OWN_D) begin
              we_q    <= d_we;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= if_addr;
              wdata_q <= '0;
            end
          end
        end
        BUSY: begin
          if (done) begin
            state_q <= RESP;
            if (own_q == OWN_D)
              d_rdata_q <= resp_d;
            else
              if_rdata_q <= resp_d;
            if (tmo)
              err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign mem_req     = (state_q == BUSY);
  assign mem_we      = mem_req && we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign if_rvalid   = (state_q == RESP) && (own_q == OWN_IF);
  assign d_rvalid    = (state_q == RESP) && (own_q == OWN_D);
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign timeout_err = err_q;

endmodule
